hms_timekeeper: RTL and testbench

- Parametrised hour:min:sec timekeeper for the display path: internal 1 Hz prescaler, sec/min/hour counters with carry chain, CLOCK/SETUP mode state machine, per-field set.
- Fully synchronous: single clk domain with enables, no derived or gated clocks.
- Inputs are one-cycle button pulses from the debounce and edge-detect stage.
- Outputs drive the digit splitter, 7-segment decoders and the multiplexed display driver.

---
 rtl/hms_timekeeper.sv | 167 ++++++++++++++++
 tb/tb_hms_timekeeper.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hms_timekeeper.sv
// Hour:min:sec timekeeper with 1 Hz prescaler, CLOCK/SETUP mode FSM and per-field set.
// Optional HMS_DECREMENT_EN adds i_dec_pls for decrementing the selected field in SETUP.
module hms_timekeeper #(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned HOUR_MAX = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_mode_pls,
  input  logic       i_pos_pls,
  input  logic       i_inc_pls,
`ifdef HMS_DECREMENT_EN
  input  logic       i_dec_pls,
`endif
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_mode,
  output logic [1:0] o_position,
  output logic       o_blink,
  output logic       o_sec_tick,
  output logic       o_day_hit
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned BW = ((CLK_HZ / 4) > 1) ? $clog2(CLK_HZ / 4) : 1;
  localparam logic [PW-1:0] PRE_TC   = PW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BLINK_TC = BW'((CLK_HZ / 4) - 1);
  localparam logic [4:0]    HOUR_TC  = 5'(HOUR_MAX);
  localparam logic [1:0]    POS_SEC  = 2'd0;
  localparam logic [1:0]    POS_MIN  = 2'd1;
  localparam logic [1:0]    POS_HOUR = 2'd2;

  typedef enum logic {CLOCK = 1'b0, SETUP = 1'b1} mode_e;

  mode_e          state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [BW-1:0]  bcnt_q, bcnt_d;
  logic [5:0]     sec_q, sec_d, min_q, min_d;
  logic [4:0]     hour_q, hour_d;
  logic [1:0]     pos_q, pos_d;
  logic           blink_q, blink_d, tick_q, tick_d, day_q, day_d;
  logic           tick_c, dec_c, up_c, dn_c;

`ifdef HMS_DECREMENT_EN
  assign dec_c = i_dec_pls;
`else
  assign dec_c = 1'b0;
`endif

  // Simultaneous inc and dec cancel each other but still count as an edit.
  assign up_c   = i_inc_pls & ~dec_c;
  assign dn_c   = dec_c & ~i_inc_pls;
  assign tick_c = (state_q == CLOCK) && (presc_q == PRE_TC);

  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] dec60(input logic [5:0] v);
    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  function automatic logic [4:0] inc_hour(input logic [4:0] v);
    return (v == HOUR_TC) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [4:0] dec_hour(input logic [4:0] v);
    return (v == 5'd0) ? HOUR_TC : v - 5'd1;
  endfunction

  // Next-state, counters and outputs.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    bcnt_d  = bcnt_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    pos_d   = pos_q;
    blink_d = blink_q;
    tick_d  = 1'b0;
    day_d   = 1'b0;

    if (tick_c) begin
      tick_d = 1'b1;
      sec_d  = inc60(sec_q);
      if (sec_q == 6'd59) begin
        min_d = inc60(min_q);
        if (min_q == 6'd59) begin
          hour_d = inc_hour(hour_q);
          day_d  = (hour_q == HOUR_TC);
        end
      end
    end

    if (state_q == CLOCK) begin
      blink_d = 1'b1;
      bcnt_d  = '0;
      presc_d = tick_c ? '0 : presc_q + PW'(1);
      if (i_mode_pls) begin
        state_d = SETUP;
        presc_d = '0;
        pos_d   = POS_SEC;
      end
    end else begin
      presc_d = '0;
      if (i_mode_pls) begin
        state_d = CLOCK;
        blink_d = 1'b1;
        bcnt_d  = '0;
      end else if (i_pos_pls || i_inc_pls || dec_c) begin
        blink_d = 1'b1;
        bcnt_d  = '0;
        if (i_pos_pls) pos_d = (pos_q == POS_HOUR) ? POS_SEC : pos_q + 2'd1;
        if (up_c || dn_c) begin
          case (pos_q)
            POS_SEC:  sec_d  = up_c ? inc60(sec_q) : dec60(sec_q);
            POS_MIN:  min_d  = up_c ? inc60(min_q) : dec60(min_q);
            default:  hour_d = up_c ? inc_hour(hour_q) : dec_hour(hour_q);
          endcase
        end
      end else if (bcnt_q == BLINK_TC) begin
        bcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLOCK;
      presc_q <= '0;
      bcnt_q  <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      pos_q   <= POS_SEC;
      blink_q <= 1'b1;
      tick_q  <= 1'b0;
      day_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      bcnt_q  <= bcnt_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      pos_q   <= pos_d;
      blink_q <= blink_d;
      tick_q  <= tick_d;
      day_q   <= day_d;
    end
  end

  assign o_sec      = sec_q;
  assign o_min      = min_q;
  assign o_hour     = hour_q;
  assign o_mode     = (state_q == SETUP);
  assign o_position = pos_q;
  assign o_blink    = blink_q;
  assign o_sec_tick = tick_q;
  assign o_day_hit  = day_q;

endmodule

// File: tb/tb_hms_timekeeper.sv
// Directed self-checking bench for hms_timekeeper at CLK_HZ=8, HOUR_MAX=23.
module tb_hms_timekeeper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode_pls, pos_pls, inc_pls;
`ifdef HMS_DECREMENT_EN
  logic       dec_pls;
`endif
  logic [5:0] sec, min;
  logic [4:0] hour;
  logic       mode, blink, sec_tick, day_hit;
  logic [1:0] position;

  int n_checks = 0;
  int n_pass   = 0;
  int tick_cnt = 0;
  int tick_ref;

  hms_timekeeper #(.CLK_HZ(8), .HOUR_MAX(23)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_mode_pls (mode_pls),
    .i_pos_pls  (pos_pls),
    .i_inc_pls  (inc_pls),
`ifdef HMS_DECREMENT_EN
    .i_dec_pls  (dec_pls),
`endif
    .o_sec      (sec),
    .o_min      (min),
    .o_hour     (hour),
    .o_mode     (mode),
    .o_position (position),
    .o_blink    (blink),
    .o_sec_tick (sec_tick),
    .o_day_hit  (day_hit)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (sec_tick) tick_cnt <= tick_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic m, input logic p, input logic i, input int n);
    for (int k = 0; k < n; k++) begin
      mode_pls = m; pos_pls = p; inc_pls = i;
      step(1);
      mode_pls = 1'b0; pos_pls = 1'b0; inc_pls = 1'b0;
    end
  endtask

`ifdef HMS_DECREMENT_EN
  task automatic pulse_dec(input logic i, input int n);
    for (int k = 0; k < n; k++) begin
      dec_pls = 1'b1; inc_pls = i;
      step(1);
      dec_pls = 1'b0; inc_pls = 1'b0;
    end
  endtask
`endif

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, "_hour"}, 32'(hour), 32'(h));
    check({tag, "_min"},  32'(min),  32'(m));
    check({tag, "_sec"},  32'(sec),  32'(s));
  endtask

  task automatic check_reset(input string tag);
    check_time(tag, 0, 0, 0);
    check({tag, "_mode"},  32'(mode),     32'd0);
    check({tag, "_pos"},   32'(position), 32'd0);
    check({tag, "_blink"}, 32'(blink),    32'd1);
    check({tag, "_tick"},  32'(sec_tick), 32'd0);
    check({tag, "_day"},   32'(day_hit),  32'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    mode_pls = 1'b0; pos_pls = 1'b0; inc_pls = 1'b0;
`ifdef HMS_DECREMENT_EN
    dec_pls = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #1 check_reset("rst");
    #1 rst_n = 1'b1;

    // First second after reset, then one full minute.
    step(7);
    check("tick_pre", 32'(sec_tick), 32'd0);
    step(1);
    check("tick_1s", 32'(sec_tick), 32'd1);
    check("sec_1s",  32'(sec),      32'd1);
    step(1);
    check("tick_off", 32'(sec_tick), 32'd0);
    step(471);
    check_time("t480", 0, 1, 0);
    check("tick_480", 32'(sec_tick), 32'd1);

    // Enter SETUP: blink at 2 cycles per phase, edit restores it.
    pulse(1, 0, 0, 1);
    check("mode_setup", 32'(mode),     32'd1);
    check("pos_entry",  32'(position), 32'd0);
    check("blink_0",    32'(blink),    32'd1);
    step(1); check("blink_1", 32'(blink), 32'd1);
    step(1); check("blink_2", 32'(blink), 32'd0);
    step(1); check("blink_3", 32'(blink), 32'd0);
    step(1); check("blink_4", 32'(blink), 32'd1);
    step(2); check("blink_6", 32'(blink), 32'd0);
    pulse(0, 0, 1, 1);
    check("blink_inc", 32'(blink), 32'd1);
    check("sec_inc1",  32'(sec),   32'd1);

    // Seconds wrap without carry, then set 23:59:58.
    pulse(0, 0, 1, 58);
    check("sec_59", 32'(sec), 32'd59);
    pulse(0, 0, 1, 1);
    check("sec_wrap",    32'(sec), 32'd0);
    check("min_nocarry", 32'(min), 32'd1);
    pulse(0, 0, 1, 58);
    pulse(0, 1, 0, 1);
    check("pos_min", 32'(position), 32'd1);
    pulse(0, 0, 1, 58);
    pulse(0, 1, 0, 1);
    check("pos_hour", 32'(position), 32'd2);
    pulse(0, 0, 1, 23);
    pulse(0, 1, 0, 1);
    check("pos_wrap", 32'(position), 32'd0);
    check_time("set", 23, 59, 58);
    tick_ref = tick_cnt;
    step(100);
    check("setup_no_tick", 32'(tick_cnt), 32'(tick_ref));
    check_time("setup_hold", 23, 59, 58);

    // Exit and roll over midnight.
    pulse(1, 0, 0, 1);
    check("mode_clock", 32'(mode),  32'd0);
    check("blink_exit", 32'(blink), 32'd1);
    step(8);
    check_time("t59", 23, 59, 59);
    check("tick_59", 32'(sec_tick), 32'd1);
    check("day_59",  32'(day_hit),  32'd0);
    step(7);
    check("tick_gap", 32'(sec_tick), 32'd0);
    step(1);
    check_time("midnight", 0, 0, 0);
    check("tick_mid", 32'(sec_tick), 32'd1);
    check("day_mid",  32'(day_hit),  32'd1);
    step(1);
    check("day_off", 32'(day_hit), 32'd0);

    // Mode wins over inc from CLOCK.
    pulse(1, 0, 1, 1);
    check("mode_inc_mode", 32'(mode), 32'd1);
    check_time("mode_inc", 0, 0, 0);
    pulse(1, 0, 0, 1);
    step(7);
    // Tick coinciding with mode pulse is still counted.
    pulse(1, 0, 0, 1);
    check("tick_mode_mode", 32'(mode),     32'd1);
    check("tick_mode_tick", 32'(sec_tick), 32'd1);
    check("tick_mode_sec",  32'(sec),      32'd1);

    // Set 00:12:34, run, then assert reset between edges.
    pulse(0, 0, 1, 33);
    pulse(0, 1, 0, 1);
    pulse(0, 0, 1, 12);
    pulse(1, 0, 0, 1);
    step(3);
    check_time("pre_rst", 0, 12, 34);
    #1 rst_n = 1'b0;
    #1 check_reset("async_rst");
    #1 rst_n = 1'b1;
    step(1);

`ifdef HMS_DECREMENT_EN
    pulse(1, 0, 0, 1);
    pulse(0, 1, 0, 2);
    check("dec_pos", 32'(position), 32'd2);
    pulse_dec(0, 1);
    check("dec_hour_wrap", 32'(hour), 32'd23);
    pulse_dec(1, 1);
    check("inc_dec_hold", 32'(hour), 32'd23);
    check("inc_dec_blink", 32'(blink), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
